// File: rtl/vec_reduce_acc.sv
// Lane-reduction accumulator: sums every lane of each accepted beat through a
// two-stage adder tree and accumulates the beat totals until a group closes on in_last.
module vec_reduce_acc #(
  parameter int LANES  = 16,
  parameter int EW     = 8,
  parameter int AW     = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*EW-1:0]   in_vec,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AW-1:0]         out_sum,
  output logic                  out_ovf
);

  localparam int NP = LANES / 4;
  localparam int PW = EW + 2;
  localparam int TW = EW + $clog2(LANES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  function automatic logic [PW-1:0] lane_ext(input logic [EW-1:0] v);
    logic [PW-1:0] r;
    r = SIGNED ? {{2{v[EW-1]}}, v} : {2'b00, v};
    return r;
  endfunction

  function automatic logic [TW-1:0] part_ext(input logic [PW-1:0] p);
    logic [TW-1:0] r;
    for (int i = 0; i < TW; i++) begin
      if (i < PW) r[i] = p[i];
      else        r[i] = SIGNED ? p[PW-1] : 1'b0;
    end
    return r;
  endfunction

  // Beat total brought to accumulator width; high bits drop if AW < TW.
  function automatic logic [AW-1:0] tot_ext(input logic [TW-1:0] t);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      if (i < TW) r[i] = t[i];
      else        r[i] = SIGNED ? t[TW-1] : 1'b0;
    end
    return r;
  endfunction

  // Wrapping add returning {overflow, sum}.
  function automatic logic [AW:0] acc_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    logic        ovf;
    s   = {1'b0, a} + {1'b0, b};
    ovf = SIGNED ? ((a[AW-1] == b[AW-1]) && (s[AW-1] != a[AW-1])) : s[AW];
    return {ovf, s[AW-1:0]};
  endfunction

  state_t          r_state;
  logic            r_busy;
  logic            r_vld_p1;
  logic            r_last_p1;
  logic [PW-1:0]   r_part_p1 [NP];
  logic [AW-1:0]   r_acc;
  logic            r_ovf;
  logic            r_out_valid;

  logic            w_accept;
  logic [PW-1:0]   w_part [NP];
  logic [TW-1:0]   w_total;
  logic [AW:0]     w_add;

  assign in_ready  = !r_busy;
  assign w_accept  = in_valid && !r_busy;
  assign out_valid = r_out_valid;
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_part[p] = '0;
      for (int k = 0; k < 4; k++)
        w_part[p] = w_part[p] + lane_ext(in_vec[(4*p+k)*EW +: EW]);
    end
  end

  always_comb begin
    w_total = '0;
    for (int p = 0; p < NP; p++)
      w_total = w_total + part_ext(r_part_p1[p]);
  end

  assign w_add = acc_add(r_acc, tot_ext(w_total));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_last_p1   <= 1'b0;
      for (int p = 0; p < NP; p++) r_part_p1[p] <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // Stage 1: four-lane partial sums
      r_vld_p1  <= w_accept;
      r_last_p1 <= w_accept && in_last;
      if (w_accept) begin
        for (int p = 0; p < NP; p++) r_part_p1[p] <= w_part[p];
      end
      // Closing the group here keeps the next group's beats out of the tree.
      if (w_accept && in_last) r_busy <= 1'b1;

      // Stage 2: partials totalled and folded into the accumulator
      if (r_vld_p1) begin
        r_acc <= w_add[AW-1:0];
        r_ovf <= r_ovf | w_add[AW];
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (r_vld_p1 && r_last_p1) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_reduce_acc.sv
// Bench for vec_reduce_acc: three configurations share one stimulus stream and are
// scored against an arithmetic model of group sums with wrap and overflow rules.
module tb_vec_reduce_acc;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [127:0] in_vec = '0;
  logic         out_ready = 1'b0;

  logic         ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [31:0]  os0, os2;
  logic [11:0]  os1;

  int n_chk = 0;
  int n_err = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  typedef struct { longint sum; bit ovf; } exp_t;
  exp_t q0[$], q1[$], q2[$];
  longint m_acc[3];
  bit     m_ovf[3];

  always #5 clk = ~clk;

  vec_reduce_acc #(.LANES(16), .EW(8), .AW(32), .SIGNED(1'b1)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_vec(in_vec),
    .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_sum(os0), .out_ovf(of0));
  vec_reduce_acc #(.LANES(16), .EW(8), .AW(12), .SIGNED(1'b1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_vec(in_vec),
    .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_sum(os1), .out_ovf(of1));
  vec_reduce_acc #(.LANES(16), .EW(8), .AW(32), .SIGNED(1'b0)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_vec(in_vec),
    .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_sum(os2), .out_ovf(of2));

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // Reference: group total is the plain sum of lane values, folded into an AW-bit
  // register that wraps; overflow whenever an exact add leaves the AW-bit range.
  function automatic void model_beat(input logic [127:0] v, input bit last);
    longint ssum, usum, md, s, n, tot;
    int     aw;
    bit     sg;
    exp_t   e;
    ssum = 0;
    usum = 0;
    for (int i = 0; i < 16; i++) begin
      byte signed b;
      b = v[i*8 +: 8];
      ssum += b;
      usum += longint'(v[i*8 +: 8]);
    end
    for (int c = 0; c < 3; c++) begin
      aw  = (c == 1) ? 12 : 32;
      sg  = (c != 2);
      md  = longint'(1) << aw;
      tot = sg ? ssum : usum;
      if (sg) begin
        s = (m_acc[c] >= md / 2) ? m_acc[c] - md : m_acc[c];
        n = s + tot;
        if (n >= md / 2 || n < -(md / 2)) m_ovf[c] = 1'b1;
      end else begin
        n = m_acc[c] + tot;
        if (n >= md) m_ovf[c] = 1'b1;
      end
      m_acc[c] = ((n % md) + md) % md;
      if (last) begin
        e.sum = m_acc[c];
        e.ovf = m_ovf[c];
        case (c)
          0:       q0.push_back(e);
          1:       q1.push_back(e);
          default: q2.push_back(e);
        endcase
        m_acc[c] = 0;
        m_ovf[c] = 1'b0;
      end
    end
  endfunction

  function automatic bit qpop(input int c, output exp_t e);
    e.sum = 0;
    e.ovf = 1'b0;
    case (c)
      0: if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  task automatic mon(input int c, input longint s, input logic o);
    exp_t e;
    if (!qpop(c, e)) begin
      n_chk++;
      n_err++;
      $display("FAIL unexpected_out%0d actual=%0h required=none", c, s);
    end else begin
      chk($sformatf("sum%0d", c), s, e.sum);
      chk($sformatf("ovf%0d", c), longint'(o), longint'(e.ovf));
    end
  endtask

  // Monitor: a result is consumed on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (ov0) mon(0, longint'(os0), of0);
      if (ov1) mon(1, longint'(os1), of1);
      if (ov2) mon(2, longint'(os2), of2);
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send_beat(input logic [127:0] v, input bit last);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = v;
    in_last  = last;
    n = 0;
    while (!ir0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir0) begin
      fail("in_ready_wait");
      in_valid = 1'b0;
    end else begin
      model_beat(v, last);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!ov0 && n < 50);
    if (!ov0) fail("out_valid_wait");
  endtask

  task automatic release_out();
    int n;
    rdy_mode = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ov0 && n < 50);
    if (ov0) fail("handshake_wait");
    else     chk("in_ready_after_hs", longint'(ir0), 1);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    for (int c = 0; c < 3; c++) begin
      m_acc[c] = 0;
      m_ovf[c] = 1'b0;
    end
    @(negedge clk);
    chk({nm, "_in_ready"}, longint'(ir0), 1);
    chk({nm, "_out_valid"}, longint'(ov0), 0);
    chk({nm, "_out_sum"}, longint'(os0), 0);
    chk({nm, "_out_ovf"}, longint'(of0), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] v;
    int nb, n;
    do_reset("reset");

    // T1: single beat, latency and value
    rdy_mode = 2;
    send_beat({16{8'h01}}, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_valid_T1", longint'(ov0), 0);
    chk("t1_busy", longint'(ir0), 0);
    @(negedge clk);
    chk("t1_valid_T2", longint'(ov0), 1);
    chk("t1_sum", longint'(os0), 16);
    chk("t1_ovf", longint'(of0), 0);
    release_out();

    // T2: three back-to-back beats of -128 lanes
    send_beat({16{8'h80}}, 1'b0);
    send_beat({16{8'h80}}, 1'b0);
    send_beat({16{8'h80}}, 1'b1);
    rdy_mode = 2;
    wait_out();
    chk("t2_sum", longint'(os0), 64'h0000_0000_FFFF_E800);
    chk("t2_ovf", longint'(of0), 0);
    release_out();

    // T3: result held while the consumer stalls
    rdy_mode = 2;
    send_beat({16{8'h01}}, 1'b1);
    wait_out();
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_valid", longint'(ov0), 1);
      chk("t3_hold_sum", longint'(os0), 16);
      chk("t3_hold_ready", longint'(ir0), 0);
    end
    release_out();
    send_beat({16{8'h02}}, 1'b1);
    rdy_mode = 2;
    wait_out();
    chk("t3_sum2", longint'(os0), 32);
    release_out();

    // T4: 12-bit signed accumulator wraps and flags overflow
    rdy_mode = 2;
    send_beat({16{8'h7F}}, 1'b0);
    send_beat({16{8'h7F}}, 1'b1);
    wait_out();
    chk("t4_sum", longint'(os1), 12'hFE0);
    chk("t4_ovf", longint'(of1), 1);
    release_out();
    send_beat({16{8'h01}}, 1'b1);
    rdy_mode = 2;
    wait_out();
    chk("t4_next_ovf", longint'(of1), 0);
    release_out();

    // T5: all-ones lanes, unsigned vs signed
    rdy_mode = 2;
    send_beat({16{8'hFF}}, 1'b1);
    wait_out();
    chk("t5_unsigned", longint'(os2), 4080);
    chk("t5_signed", longint'(os0), 64'h0000_0000_FFFF_FFF0);
    release_out();

    // T6: reset mid-group and in HOLD discards everything
    send_beat({16{8'h05}}, 1'b0);
    idle(2);
    send_beat({16{8'h09}}, 1'b0);
    idle(1);
    do_reset("t6_midgroup");
    rdy_mode = 2;
    send_beat({16{8'h03}}, 1'b1);
    wait_out();
    do_reset("t6_hold");
    rdy_mode = 0;
    send_beat({16{8'h01}}, 1'b1);
    rdy_mode = 2;
    wait_out();
    chk("t6_sum", longint'(os0), 16);
    release_out();

    // Randomized groups with random back-pressure
    rdy_mode = 1;
    for (int g = 0; g < 40; g++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(0, 5))
          0:       v = {16{8'h7F}};
          1:       v = {16{8'h80}};
          default: v = {$urandom(), $urandom(), $urandom(), $urandom()};
        endcase
        send_beat(v, b == nb - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(1);
    rdy_mode = 0;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", longint'(q0.size()), 0);
    chk("drain_q1", longint'(q1.size()), 0);
    chk("drain_q2", longint'(q2.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
